// File: rtl/ball_motion_ctrl_if.sv
// Signal bundle between the frame timing / control logic and the ball motion sequencer.
// The master drives frame and control inputs; the slave (sequencer) returns the committed sprite state.
interface ball_motion_ctrl_if;
  logic       i_frame_start;
  logic       i_pause;
  logic       i_step;
  logic [2:0] i_speed_x;
  logic [2:0] i_speed_y;
  logic [9:0] o_ball_x;
  logic [9:0] o_ball_y;
  logic       o_dir_x;
  logic       o_dir_y;
  logic       o_busy;
  logic       o_bounce_pulse;
  logic [7:0] o_bounce_count;
  logic       o_flash_active;
  logic       o_overrun;

  modport master (
    output i_frame_start, i_pause, i_step, i_speed_x, i_speed_y,
    input  o_ball_x, o_ball_y, o_dir_x, o_dir_y, o_busy,
    input  o_bounce_pulse, o_bounce_count, o_flash_active, o_overrun
  );

  modport slave (
    input  i_frame_start, i_pause, i_step, i_speed_x, i_speed_y,
    output o_ball_x, o_ball_y, o_dir_x, o_dir_y, o_busy,
    output o_bounce_pulse, o_bounce_count, o_flash_active, o_overrun
  );
endinterface

// File: rtl/ball_motion_ctrl.sv
// Per-frame bouncing-ball motion sequencer: IDLE -> CALC_X -> CALC_Y -> COMMIT, with edge clamping,
// atomic commit of position/direction, pause/single-step, bounce counter and post-bounce flash timer.
module ball_motion_ctrl #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int RADIUS       = 20,
  parameter int X_INIT       = 320,
  parameter int Y_INIT       = 240,
  parameter int FLASH_FRAMES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  ball_motion_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC_X = 2'd1,
    S_CALC_Y = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  localparam logic [10:0] EDGE_LO    = 11'(RADIUS);
  localparam logic [10:0] X_HI       = 11'(H_ACTIVE - RADIUS);
  localparam logic [10:0] Y_HI       = 11'(V_ACTIVE - RADIUS);
  localparam logic [9:0]  X_RESET    = 10'(X_INIT);
  localparam logic [9:0]  Y_RESET    = 10'(Y_INIT);
  localparam logic [3:0]  FLASH_LOAD = 4'(FLASH_FRAMES);

  // One axis step in 11-bit arithmetic; landing on or past an edge clamps and flips.
  // Result packs {new_pos[9:0], new_dir, bounced}.
  function automatic logic [11:0] f_axis_step(
    input logic [9:0]  pos,
    input logic        dir,
    input logic [2:0]  spd,
    input logic [10:0] hi
  );
    logic [10:0] p;
    logic [10:0] s;
    logic [10:0] n;
    logic [10:0] d;
    p = {1'b0, pos};
    s = {8'd0, spd};
    n = p + s;
    d = p - s;
    if (dir) begin
      if (n >= hi) begin
        f_axis_step = {hi[9:0], 1'b0, 1'b1};
      end else begin
        f_axis_step = {n[9:0], 1'b1, 1'b0};
      end
    end else begin
      if (p <= (EDGE_LO + s)) begin
        f_axis_step = {EDGE_LO[9:0], 1'b1, 1'b1};
      end else begin
        f_axis_step = {d[9:0], 1'b0, 1'b0};
      end
    end
  endfunction

  state_t      r_state;
  state_t      w_next_state;
  logic        w_start;
  logic [2:0]  r_sx;
  logic [2:0]  r_sy;
  logic [9:0]  r_nx;
  logic [9:0]  r_ny;
  logic        r_ndx;
  logic        r_ndy;
  logic        r_bx;
  logic        r_by;
  logic [11:0] w_x_res;
  logic [11:0] w_y_res;

  logic [9:0]  r_ball_x;
  logic [9:0]  r_ball_y;
  logic        r_dir_x;
  logic        r_dir_y;
  logic        r_busy;
  logic        r_bounce_pulse;
  logic [7:0]  r_bounce_count;
  logic [3:0]  r_flash_cnt;
  logic        r_flash_active;
  logic        r_overrun;
  logic        r_step_pending;

  logic        w_commit_bounce;
  logic [8:0]  w_count_sum;
  logic [7:0]  w_count_next;
  logic [3:0]  w_flash_next;

  assign w_x_res = f_axis_step(r_ball_x, r_dir_x, r_sx, X_HI);
  assign w_y_res = f_axis_step(r_ball_y, r_dir_y, r_sy, Y_HI);

  assign w_commit_bounce = (r_state == S_COMMIT) && (r_bx || r_by);
  assign w_count_sum     = {1'b0, r_bounce_count} + {8'd0, r_bx} + {8'd0, r_by};
  assign w_count_next    = w_count_sum[8] ? 8'hFF : w_count_sum[7:0];

  // Next-state logic; pause is only looked at while idle so an update in flight always finishes.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_frame_start && (!bus.i_pause || r_step_pending)) begin
          w_next_state = S_CALC_X;
          w_start      = 1'b1;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_CALC_X: w_next_state = S_CALC_Y;
      S_CALC_Y: w_next_state = S_COMMIT;
      S_COMMIT: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Flash timer: a bounce commit reload takes precedence over the per-frame decrement.
  always_comb begin
    w_flash_next = r_flash_cnt;
    if (w_commit_bounce) begin
      w_flash_next = FLASH_LOAD;
    end else if (bus.i_frame_start && (r_flash_cnt != 4'd0)) begin
      w_flash_next = r_flash_cnt - 4'd1;
    end else begin
      w_flash_next = r_flash_cnt;
    end
  end

  // FSM state and the working registers for the update in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sx    <= 3'd0;
      r_sy    <= 3'd0;
      r_nx    <= 10'd0;
      r_ny    <= 10'd0;
      r_ndx   <= 1'b0;
      r_ndy   <= 1'b0;
      r_bx    <= 1'b0;
      r_by    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_start) begin
        r_sx <= bus.i_speed_x;
        r_sy <= bus.i_speed_y;
      end
      if (r_state == S_CALC_X) begin
        {r_nx, r_ndx, r_bx} <= w_x_res;
      end
      if (r_state == S_CALC_Y) begin
        {r_ny, r_ndy, r_by} <= w_y_res;
      end
    end
  end

  // Committed sprite state; everything the renderer sees changes on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ball_x       <= X_RESET;
      r_ball_y       <= Y_RESET;
      r_dir_x        <= 1'b1;
      r_dir_y        <= 1'b1;
      r_bounce_pulse <= 1'b0;
      r_bounce_count <= 8'd0;
    end else begin
      r_bounce_pulse <= w_commit_bounce;
      if (r_state == S_COMMIT) begin
        r_ball_x <= r_nx;
        r_ball_y <= r_ny;
        r_dir_x  <= r_ndx;
        r_dir_y  <= r_ndy;
      end
      if (w_commit_bounce) begin
        r_bounce_count <= w_count_next;
      end
    end
  end

  // Status flags: busy, sticky overrun, pending single-step and flash timer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy         <= 1'b0;
      r_overrun      <= 1'b0;
      r_step_pending <= 1'b0;
      r_flash_cnt    <= 4'd0;
      r_flash_active <= 1'b0;
    end else begin
      r_busy         <= (w_next_state != S_IDLE);
      r_flash_cnt    <= w_flash_next;
      r_flash_active <= (w_flash_next != 4'd0);
      if (bus.i_frame_start && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
      if (w_start) begin
        r_step_pending <= 1'b0;
      end else if (bus.i_step && bus.i_pause) begin
        r_step_pending <= 1'b1;
      end
    end
  end

  assign bus.o_ball_x       = r_ball_x;
  assign bus.o_ball_y       = r_ball_y;
  assign bus.o_dir_x        = r_dir_x;
  assign bus.o_dir_y        = r_dir_y;
  assign bus.o_busy         = r_busy;
  assign bus.o_bounce_pulse = r_bounce_pulse;
  assign bus.o_bounce_count = r_bounce_count;
  assign bus.o_flash_active = r_flash_active;
  assign bus.o_overrun      = r_overrun;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Self-checking bench for ball_motion_ctrl: a behavioural model pushes the expected committed state
// per frame onto a scoreboard queue, popped and compared once the update becomes visible.
module tb_ball_motion_ctrl;

  logic clk;
  logic rst_n;
  ball_motion_ctrl_if bus();

  ball_motion_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit dx;
    bit dy;
    int cnt;
    bit flash;
    bit pulse;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;
  int   pulses_seen;

  int m_x, m_y, m_cnt, m_flash;
  bit m_dx, m_dy, m_pending;
  int cur_sx, cur_sy;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_x = 320; m_y = 240; m_dx = 1'b1; m_dy = 1'b1;
    m_cnt = 0; m_flash = 0; m_pending = 1'b0;
    sb.delete();
  endtask

  function automatic void model_axis(input int pos, input bit dir, input int spd, input int hi,
                                     output int npos, output bit ndir, output bit b);
    if (dir) begin
      if (pos + spd >= hi) begin npos = hi; ndir = 1'b0; b = 1'b1; end
      else begin npos = pos + spd; ndir = 1'b1; b = 1'b0; end
    end else begin
      if (pos <= 20 + spd) begin npos = 20; ndir = 1'b1; b = 1'b1; end
      else begin npos = pos - spd; ndir = 1'b0; b = 1'b0; end
    end
  endfunction

  // Apply one frame_start to the model; returns whether an update runs and pushes the expectation.
  task automatic model_frame(output bit upd);
    exp_t e;
    int nx, ny;
    bit ndx, ndy, bx, by;
    bx = 1'b0; by = 1'b0;
    upd = (!bus.i_pause) || m_pending;
    if (m_flash > 0) m_flash--;
    if (upd) begin
      m_pending = 1'b0;
      model_axis(m_x, m_dx, cur_sx, 620, nx, ndx, bx);
      model_axis(m_y, m_dy, cur_sy, 460, ny, ndy, by);
      m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
      m_cnt = m_cnt + int'(bx) + int'(by);
      if (m_cnt > 255) m_cnt = 255;
      if (bx || by) m_flash = 8;
    end
    e.x = m_x; e.y = m_y; e.dx = m_dx; e.dy = m_dy; e.cnt = m_cnt;
    e.flash = (m_flash != 0); e.pulse = upd && (bx || by);
    sb.push_back(e);
  endtask

  task automatic sb_compare(input string tag);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      if ({bus.o_ball_x, bus.o_ball_y} !== {10'(e.x), 10'(e.y)}) begin
        failures++;
        $display("FAIL %s pos got (%0d,%0d) exp (%0d,%0d)", tag, bus.o_ball_x, bus.o_ball_y, e.x, e.y);
      end
      checks++;
      if ({bus.o_dir_x, bus.o_dir_y} !== {e.dx, e.dy}) begin
        failures++;
        $display("FAIL %s dir got %b%b exp %b%b", tag, bus.o_dir_x, bus.o_dir_y, e.dx, e.dy);
      end
      checks++;
      if (bus.o_bounce_count !== 8'(e.cnt)) begin
        failures++;
        $display("FAIL %s bounce_count got %0d exp %0d", tag, bus.o_bounce_count, e.cnt);
      end
      checks++;
      if (bus.o_flash_active !== e.flash) begin
        failures++;
        $display("FAIL %s flash_active got %b exp %b", tag, bus.o_flash_active, e.flash);
      end
      checks++;
      if (bus.o_bounce_pulse !== e.pulse) begin
        failures++;
        $display("FAIL %s bounce_pulse got %b exp %b", tag, bus.o_bounce_pulse, e.pulse);
      end
    end
  endtask

  // frame_start at T, busy checked T+1..T+3, scoreboard compared at T+4, pulse must drop at T+5.
  task automatic run_frame(input string tag);
    bit upd;
    model_frame(upd);
    bus.i_frame_start = 1'b1;
    tick();
    bus.i_frame_start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (bus.o_busy !== upd) begin
        failures++;
        $display("FAIL %s busy@T+%0d got %b exp %b", tag, k, bus.o_busy, upd);
      end
      tick();
    end
    if (bus.o_bounce_pulse === 1'b1) pulses_seen++;
    sb_compare(tag);
    tick();
    checks++;
    if (bus.o_bounce_pulse !== 1'b0) begin
      failures++;
      $display("FAIL %s bounce_pulse_width got %b exp 0", tag, bus.o_bounce_pulse);
    end
    tick();
  endtask

  task automatic check_idle_state(input string tag);
    checks++;
    if ({bus.o_ball_x, bus.o_ball_y, bus.o_dir_x, bus.o_dir_y} !== {10'd320, 10'd240, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL %s pos/dir got (%0d,%0d) %b%b exp (320,240) 11", tag,
               bus.o_ball_x, bus.o_ball_y, bus.o_dir_x, bus.o_dir_y);
    end
    checks++;
    if ({bus.o_busy, bus.o_overrun, bus.o_flash_active, bus.o_bounce_pulse, bus.o_bounce_count} !== 12'd0) begin
      failures++;
      $display("FAIL %s status got busy=%b ovr=%b flash=%b pulse=%b cnt=%0d exp all 0", tag,
               bus.o_busy, bus.o_overrun, bus.o_flash_active, bus.o_bounce_pulse, bus.o_bounce_count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) tick();
    check_idle_state("reset");
  endtask

  task automatic test_basic();
    cur_sx = 2; cur_sy = 2;
    bus.i_speed_x = 3'd2; bus.i_speed_y = 3'd2;
    run_frame("basic");
    checks++;
    if ({bus.o_ball_x, bus.o_ball_y} !== {10'd322, 10'd242}) begin
      failures++;
      $display("FAIL basic_abs got (%0d,%0d) exp (322,242)", bus.o_ball_x, bus.o_ball_y);
    end
  endtask

  task automatic test_overrun();
    bit upd;
    model_frame(upd);
    bus.i_frame_start = 1'b1;
    tick();
    bus.i_frame_start = 1'b0;
    tick();
    bus.i_frame_start = 1'b1;
    tick();
    bus.i_frame_start = 1'b0;
    tick();
    sb_compare("overrun");
    checks++;
    if (bus.o_overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_flag got %b exp 1", bus.o_overrun);
    end
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if ({bus.o_ball_x, bus.o_ball_y, bus.o_busy} !== {10'(m_x), 10'(m_y), 1'b0}) begin
      failures++;
      $display("FAIL overrun_once got (%0d,%0d) busy=%b exp (%0d,%0d) busy=0",
               bus.o_ball_x, bus.o_ball_y, bus.o_busy, m_x, m_y);
    end
  endtask

  task automatic test_reset_mid();
    bus.i_frame_start = 1'b1;
    tick();
    bus.i_frame_start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check_idle_state("reset_mid");
    rst_n = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic test_bounce();
    cur_sx = 7; cur_sy = 0;
    bus.i_speed_x = 3'd7; bus.i_speed_y = 3'd0;
    pulses_seen = 0;
    for (int i = 0; i < 43; i++) run_frame("bounce_run");
    checks++;
    if ({bus.o_ball_x, bus.o_dir_x, bus.o_bounce_count} !== {10'd620, 1'b0, 8'd1} || pulses_seen != 1) begin
      failures++;
      $display("FAIL bounce_edge got x=%0d dx=%b cnt=%0d pulses=%0d exp x=620 dx=0 cnt=1 pulses=1",
               bus.o_ball_x, bus.o_dir_x, bus.o_bounce_count, pulses_seen);
    end
    for (int i = 1; i <= 8; i++) begin
      run_frame("bounce_flash");
      if (i == 1) begin
        checks++;
        if (bus.o_ball_x !== 10'd613) begin
          failures++;
          $display("FAIL bounce_return got x=%0d exp 613", bus.o_ball_x);
        end
      end
      checks++;
      if (bus.o_flash_active !== (i < 8)) begin
        failures++;
        $display("FAIL flash_len frame %0d got %b exp %b", i, bus.o_flash_active, (i < 8));
      end
    end
  endtask

  task automatic test_pause_step();
    int held_x;
    bus.i_step = 1'b1;
    tick();
    bus.i_step = 1'b0;
    bus.i_pause = 1'b1;
    tick();
    held_x = m_x;
    for (int i = 0; i < 5; i++) run_frame("pause_frozen");
    checks++;
    if (bus.o_ball_x !== 10'(held_x)) begin
      failures++;
      $display("FAIL pause_hold got x=%0d exp %0d", bus.o_ball_x, held_x);
    end
    bus.i_step = 1'b1;
    if (bus.i_pause) m_pending = 1'b1;
    tick();
    bus.i_step = 1'b0;
    tick();
    run_frame("step_update");
    checks++;
    if (bus.o_ball_x !== 10'(held_x - 7)) begin
      failures++;
      $display("FAIL step_once got x=%0d exp %0d", bus.o_ball_x, held_x - 7);
    end
    for (int i = 0; i < 3; i++) run_frame("step_frozen");
    bus.i_pause = 1'b0;
    run_frame("resume");
  endtask

  initial begin
    checks = 0; failures = 0; pulses_seen = 0;
    cur_sx = 0; cur_sy = 0;
    rst_n = 1'b0;
    bus.i_frame_start = 1'b0;
    bus.i_pause = 1'b0;
    bus.i_step = 1'b0;
    bus.i_speed_x = 3'd0;
    bus.i_speed_y = 3'd0;
    model_reset();
    test_reset();
    test_basic();
    test_overrun();
    test_reset_mid();
    test_bounce();
    test_pause_step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
